// File: rtl/multi_tick.sv
// Multi-channel programmable tick generator: per-channel period, periodic/one-shot mode and enable.
// Define MULTI_TICK_ALIGN_EN to restart a channel's count whenever its period is written.
module multi_tick #(
    parameter int N        = 20,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] oneshot,
    input  logic                div_we,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [N-1:0]        div_data,
    output logic [CHANNELS-1:0] m_tick,
    output logic [CHANNELS-1:0] done
);

`ifdef MULTI_TICK_ALIGN_EN
    localparam bit ALIGN_ON_WRITE = 1'b1;
`else
    localparam bit ALIGN_ON_WRITE = 1'b0;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [N-1:0] period_q, period_d;
        logic [N-1:0] count_q, count_d;
        logic         tick_q, tick_d;
        logic         done_q, done_d;
        logic         wr_hit;

        // Only indices below CHANNELS exist, so out-of-range selects match nothing.
        assign wr_hit = div_we && (div_sel == SEL_W'(g));

        always_comb begin
            period_d = period_q;
            count_d  = count_q;
            tick_d   = 1'b0;
            done_d   = done_q;

            if (!ch_en[g]) begin
                count_d = '0;
                done_d  = 1'b0;
            end else if (en && !done_q) begin
                // Terminal compares against the period in force before any same-cycle write.
                if (count_q >= period_q) begin
                    tick_d  = 1'b1;
                    count_d = '0;
                    done_d  = oneshot[g] && !wr_hit;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            if (wr_hit) begin
                period_d = div_data;
                done_d   = 1'b0;
                if (ALIGN_ON_WRITE) begin
                    count_d = '0;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                period_q <= '1;
                count_q  <= '0;
                tick_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                period_q <= period_d;
                count_q  <= count_d;
                tick_q   <= tick_d;
                done_q   <= done_d;
            end
        end

        assign m_tick[g] = tick_q;
        assign done[g]   = done_q;
    end

endmodule

// File: tb/tb_multi_tick.sv
// Self-checking bench for multi_tick: directed scenarios plus randomized traffic against a
// cycle-level behavioural model; a CHANNELS=3 instance shadows channels 0..2.
module tb_multi_tick;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] oneshot;
    logic          div_we;
    logic [SW-1:0] div_sel;
    logic [N-1:0]  div_data;
    logic [CH-1:0] m_tick;
    logic [CH-1:0] done;
    logic [2:0]    m_tick3;
    logic [2:0]    done3;

    int checks   = 0;
    int failures = 0;

    int            mp [CH];
    int            mc [CH];
    logic [CH-1:0] exp_tick;
    logic [CH-1:0] exp_done;

    always #5 clock = ~clock;

    multi_tick #(.N(N), .CHANNELS(CH)) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .ch_en   (ch_en),
        .oneshot (oneshot),
        .div_we  (div_we),
        .div_sel (div_sel),
        .div_data(div_data),
        .m_tick  (m_tick),
        .done    (done)
    );

    multi_tick #(.N(N), .CHANNELS(3)) dut3 (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .ch_en   (ch_en[2:0]),
        .oneshot (oneshot[2:0]),
        .div_we  (div_we),
        .div_sel (div_sel),
        .div_data(div_data),
        .m_tick  (m_tick3),
        .done    (done3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    function automatic void model_edge();
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                mp[i] = (1 << N) - 1;
                mc[i] = 0;
            end
            exp_tick = '0;
            exp_done = '0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            bit wr;
            bit t;
            wr = div_we && (int'(div_sel) == i);
            t  = 1'b0;
            if (!ch_en[i]) begin
                mc[i]       = 0;
                exp_done[i] = 1'b0;
            end else if (en && !exp_done[i]) begin
                if (mc[i] >= mp[i]) begin
                    t     = 1'b1;
                    mc[i] = 0;
                    if (oneshot[i] && !wr) exp_done[i] = 1'b1;
                end else begin
                    mc[i] = mc[i] + 1;
                end
            end
            if (wr) begin
                mp[i]       = int'(div_data);
                exp_done[i] = 1'b0;
`ifdef MULTI_TICK_ALIGN_EN
                mc[i] = 0;
`endif
            end
            exp_tick[i] = t;
        end
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("m_tick", m_tick, exp_tick);
        chk("done", done, exp_done);
        chk("m_tick3", m_tick3, exp_tick[2:0]);
        chk("done3", done3, exp_done[2:0]);
    endtask

    task automatic write(input int ch, input int p);
        div_we   = 1'b1;
        div_sel  = SW'(ch);
        div_data = N'(p);
        step();
        div_we   = 1'b0;
    endtask

    // Steps until channel ch ticks; n is the number of edges taken.
    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!m_tick[ch] && n < limit);
        chk("tick_seen", m_tick[ch], 1);
    endtask

    initial begin
        int n;
        int r;
        reset    = 1'b0;
        en       = 1'b1;
        ch_en    = '1;
        oneshot  = '0;
        div_we   = 1'b0;
        div_sel  = '0;
        div_data = '0;
        for (int i = 0; i < CH; i++) begin
            mp[i] = 0;
            mc[i] = 0;
        end
        exp_tick = '0;
        exp_done = '0;

        // Reset and default 2^N period
        repeat (3) step();
        chk("reset_tick", m_tick, 0);
        reset = 1'b1;
        wait_tick(0, 300, n);
        chk("first_tick_edges", n, 256);
        chk("all_four_tick", m_tick, 4'hF);
        wait_tick(0, 300, n);
        chk("default_period", n, 256);

        // Periodic with pause
        write(1, 4);
        wait_tick(1, 300, n);
        wait_tick(1, 20, n);
        chk("period5", n, 5);
        step();
        step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_tick(1, 20, n);
        chk("paused_period", n + 5, 8);

        // One-shot, then re-arm by rewriting the period
        oneshot[2] = 1'b1;
        ch_en[2]   = 1'b0;
        write(2, 2);
        ch_en[2] = 1'b1;
        wait_tick(2, 20, n);
        chk("oneshot_latency", n, 3);
        chk("oneshot_done", done[2], 1);
        repeat (10) step();
        write(2, 2);
        chk("done_cleared", done[2], 0);
        wait_tick(2, 20, n);
        chk("oneshot_rearm", n, 3);

        // Shrink the period while running
        ch_en[0] = 1'b0;
        write(0, 20);
        ch_en[0] = 1'b1;
        repeat (10) step();
        write(0, 5);
        wait_tick(0, 40, n);
`ifdef MULTI_TICK_ALIGN_EN
        chk("shrink_first", n, 6);
`else
        chk("shrink_first", n, 1);
`endif
        wait_tick(0, 40, n);
        chk("shrink_period", n, 6);

        // Write colliding with the terminal cycle, one-shot mode armed
        ch_en[3] = 1'b0;
        write(3, 3);
        ch_en[3]   = 1'b1;
        oneshot[3] = 1'b1;
        repeat (3) step();
        write(3, 6);
        chk("collide_tick", m_tick[3], 1);
        chk("collide_no_done", done[3], 0);
        wait_tick(3, 20, n);
        chk("collide_next", n, 7);
        chk("collide_then_done", done[3], 1);
        oneshot[3] = 1'b0;

        // Out-of-range select for the three-channel instance
        write(3, 1);
        repeat (4) step();

        // Channel enable override and mid-tick reset
        repeat (2) step();
        ch_en[1] = 1'b0;
        step();
        ch_en[1] = 1'b1;
        wait_tick(1, 20, n);
        chk("reenable", n, 5);
        wait_tick(1, 20, n);
        reset = 1'b0;
        step();
        chk("reset_clears_tick", m_tick, 0);
        reset = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom_range(0, CH - 1);
                ch_en[r] = ~ch_en[r];
            end
            if ($urandom_range(0, 29) == 0) begin
                r = $urandom_range(0, CH - 1);
                oneshot[r] = ~oneshot[r];
            end
            div_we   = ($urandom_range(0, 7) == 0);
            div_sel  = SW'($urandom_range(0, CH - 1));
            div_data = ($urandom_range(0, 15) == 0) ? N'($urandom_range(0, 255))
                                                    : N'($urandom_range(0, 12));
            reset    = ($urandom_range(0, 599) != 0);
            step();
        end
        reset  = 1'b1;
        div_we = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
